clock_display_scanner: RTL and testbench

- Downstream consumer of the BCD time digits (HH:MM:SS) produced by the digital clock core.
- Time-multiplexes six digits onto a common-anode/cathode 7-segment display: refresh counter, digit scan, anti-ghost blanking and BCD-to-segment decode.
- Snapshots all six digits once per scan frame so a frame never mixes two times. Sits between the clock core and the board pins.

---
 rtl/clock_disp_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/clock_display_scanner.sv | 132 +++++++++++++
 tb/tb_clock_display_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared digit indices, segment encodings and BCD type for the display scanner
package clock_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
    localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
    localparam logic [2:0] IDX_HOUR_TENS = 3'd5;

    // Logical (active-high) encodings, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to logical 7-segment decode, dash for non-BCD codes
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    // Codes 10..15 are not valid BCD; show a dash so a bad input is visible rather than garbage
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scanner.sv
// rtl/clock_display_scanner.sv - six-digit 7-segment scanner with per-frame snapshot; LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit
module clock_display_scanner
    import clock_disp_pkg::*;
#(
    parameter int CLK_HZ         = 5_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYCLES   = 50,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] hour_tens,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int TICKS = CLK_HZ / SCAN_HZ;
    localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    // XOR masks turning logical levels into pin levels
    localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_XOR  = (SEG_ACTIVE_LOW != 0);
    localparam logic [5:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    if (TICKS < 4) begin : g_ticks_too_small
        $error("clock_display_scanner: CLK_HZ/SCAN_HZ must be at least 4");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= TICKS) begin : g_blank_out_of_range
        $error("clock_display_scanner: BLANK_CYCLES must be in 0..TICKS-1");
    end

    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    bcd_t [NUM_DIGITS-1:0] snap;

    logic       slot_end;
    logic       frame_end;
    logic       active;
    bcd_t       cur_digit;
    logic [6:0] dec_seg;
    logic [6:0] seg_log;
    logic [5:0] an_log;
    logic       dp_log;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_HOUR_TENS);

    // Slot counter, digit index and frame snapshot; the snapshot only moves at the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= IDX_SEC_ONES;
            snap <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            if (frame_end) begin
                idx  <= IDX_SEC_ONES;
                snap <= {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
            end else begin
                idx <= idx + 3'd1;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pick the snapshot digit belonging to the current slot
    always_comb begin
        cur_digit = '0;
        case (idx)
            IDX_SEC_ONES:  cur_digit = snap[0];
            IDX_SEC_TENS:  cur_digit = snap[1];
            IDX_MIN_ONES:  cur_digit = snap[2];
            IDX_MIN_TENS:  cur_digit = snap[3];
            IDX_HOUR_ONES: cur_digit = snap[4];
            IDX_HOUR_TENS: cur_digit = snap[5];
            default:       cur_digit = '0;
        endcase
    end

    bcd_to_seg7 u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Logical pin values: everything dark during the anti-ghost window at the start of a slot
    always_comb begin
        active  = (cnt >= CNT_BLANK);
        an_log  = '0;
        seg_log = SEG_BLANK;
        dp_log  = 1'b0;
        if (active) begin
            an_log  = 6'b000001 << idx;
            seg_log = dec_seg;
            // Separators sit after the minutes and hours digits and blink with the seconds LSB
            dp_log  = ((idx == IDX_MIN_ONES) || (idx == IDX_HOUR_ONES)) && snap[0][0];
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx == IDX_HOUR_TENS) && (snap[5] == 4'd0)) begin
                seg_log = SEG_BLANK;
                dp_log  = 1'b0;
            end
`endif
        end
    end

    // Registered pin stage with polarity applied; reset drives every pin to its inactive level
    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= SEG_BLANK ^ SEG_XOR;
            dp          <= DP_XOR;
            an          <= AN_XOR;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_log ^ SEG_XOR;
            dp          <= dp_log ^ DP_XOR;
            an          <= an_log ^ AN_XOR;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_clock_display_scanner.sv
// tb/tb_clock_display_scanner.sv - table-driven self-checking bench for clock_display_scanner
module tb_clock_display_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    clock_display_scanner #(
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .hour_ones   (hour_ones),
        .hour_tens   (hour_tens),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ht, ho, mt, mo, st, so;
        int         slot;
        int         cyc;
        logic [6:0] seg;
        logic [5:0] an;
        logic       dp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_time(input logic [3:0] ht, ho, mt, mo, st, so);
        hour_tens = ht; hour_ones = ho; min_tens = mt;
        min_ones  = mo; sec_tens  = st; sec_ones = so;
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: frame_start not seen within 200 clks", name);
        end
    endtask

    task automatic check_pins(input string name, input logic [6:0] s, input logic [5:0] a, input logic d);
        check({name, "_seg"}, 32'(seg), 32'(s));
        check({name, "_an"},  32'(an),  32'(a));
        check({name, "_dp"},  32'(dp),  32'(d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [6:0] lz_seg;
        int gap;
        bit exp_on;

`ifdef LEADING_ZERO_BLANK_EN
        lz_seg = 7'h7F;
`else
        lz_seg = 7'h40;
`endif
        //           ht    ho    mt    mo    st    so   slot cyc  seg    an    dp
        vecs[0]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 5, 5, 7'h79, 6'h1F, 1'b1};
        vecs[1]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 2, 2, 7'h19, 6'h3B, 1'b1};
        vecs[2]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 2, 1, 7'h7F, 6'h3F, 1'b1};
        vecs[3]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 0, 9, 7'h02, 6'h3E, 1'b1};
        vecs[4]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 0, 5, 7'h78, 6'h3E, 1'b1};
        vecs[5]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 2, 5, 7'h19, 6'h3B, 1'b0};
        vecs[6]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4, 3, 7'h24, 6'h2F, 1'b0};
        vecs[7]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 2, 0, 7'h7F, 6'h3F, 1'b1};
        vecs[8]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 0, 4, 7'h3F, 6'h3E, 1'b1};
        vecs[9]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 2, 7, 7'h19, 6'h3B, 1'b0};
        vecs[10] = '{4'h0, 4'h9, 4'h8, 4'h7, 4'h1, 4'h0, 1, 6, 7'h79, 6'h3D, 1'b1};
        vecs[11] = '{4'h0, 4'h9, 4'h8, 4'h7, 4'h1, 4'h0, 3, 7, 7'h00, 6'h37, 1'b1};
        vecs[12] = '{4'h0, 4'h9, 4'h8, 4'h7, 4'h1, 4'h0, 5, 2, lz_seg, 6'h1F, 1'b1};
        vecs[13] = '{4'h0, 4'h9, 4'h8, 4'h7, 4'h1, 4'h0, 4, 9, 7'h10, 6'h2F, 1'b1};
        vecs[14] = '{4'hF, 4'h0, 4'h2, 4'h5, 4'h3, 4'h3, 5, 3, 7'h3F, 6'h1F, 1'b1};
        vecs[15] = '{4'hF, 4'h0, 4'h2, 4'h5, 4'h3, 4'h3, 3, 4, 7'h24, 6'h37, 1'b1};
        vecs[16] = '{4'hF, 4'h0, 4'h2, 4'h5, 4'h3, 4'h3, 2, 8, 7'h12, 6'h3B, 1'b0};
        vecs[17] = '{4'hF, 4'h0, 4'h2, 4'h5, 4'h3, 4'h3, 1, 2, 7'h30, 6'h3D, 1'b1};

        // Reset held with a live time on the inputs
        reset = 1'b1;
        set_time(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        @(negedge clk);
        check_pins("rst_hold", 7'h7F, 6'h3F, 1'b1);
        check("rst_hold_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First frame comes from the zeroed snapshot: slot 0 lit on cycles 3..10
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            exp_on = (i >= 3) && (i <= 10);
            check($sformatf("first_slot0_c%0d_seg", i), 32'(seg), exp_on ? 32'h40 : 32'h7F);
            check($sformatf("first_slot0_c%0d_an", i),  32'(an),  exp_on ? 32'h3E : 32'h3F);
            check($sformatf("first_slot0_c%0d_fs", i),  32'(frame_start), 32'd0);
        end

        // frame_start is a single-cycle pulse every 60 clocks
        wait_frame("period_a");
        @(negedge clk);
        check("fs_width", 32'(frame_start), 32'd0);
        gap = 1;
        while (!frame_start && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("fs_period", 32'(gap), 32'd60);

        // Directed vectors: load inputs, wait for their snapshot, then probe one slot/cycle
        for (int v = 0; v < 18; v++) begin
            set_time(vecs[v].ht, vecs[v].ho, vecs[v].mt, vecs[v].mo, vecs[v].st, vecs[v].so);
            wait_frame($sformatf("v%0d_wait", v));
            repeat (vecs[v].slot * 10 + vecs[v].cyc + 1) @(negedge clk);
            check_pins($sformatf("v%0d", v), vecs[v].seg, vecs[v].an, vecs[v].dp);
        end

        // Inputs changed mid-frame stay invisible until the next snapshot
        set_time(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        wait_frame("mid_wait0");
        repeat (25) @(negedge clk);
        check_pins("mid_slot2", 7'h19, 6'h3B, 1'b1);
        set_time(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7);
        repeat (20) @(negedge clk);
        check_pins("mid_slot4_old", 7'h24, 6'h2F, 1'b1);
        wait_frame("mid_wait1");
        repeat (6) @(negedge clk);
        check_pins("mid_next_slot0", 7'h78, 6'h3E, 1'b1);
        repeat (20) @(negedge clk);
        check_pins("mid_next_slot2", 7'h19, 6'h3B, 1'b0);
        repeat (20) @(negedge clk);
        check_pins("mid_next_slot4", 7'h24, 6'h2F, 1'b0);

        // One-clock reset in slot 3 clears counters and snapshot
        set_time(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        wait_frame("rst_mid_wait");
        repeat (35) @(negedge clk);
        check_pins("pre_rst_slot3", 7'h30, 6'h37, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_pins("rst_mid", 7'h7F, 6'h3F, 1'b1);
        check("rst_mid_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_pins("post_rst_blank", 7'h7F, 6'h3F, 1'b1);
        @(negedge clk);
        check_pins("post_rst_slot0", 7'h40, 6'h3E, 1'b1);
        gap = 3;
        while (!frame_start && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("post_rst_first_fs", 32'(gap), 32'd60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
